// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port RAM arbiter:
//   AW_DEFAULT / DW_DEFAULT : default RAM address and data widths
//   PORT_A / PORT_B         : port identifiers used by the arbiter and the
//                             in-flight tracking pipeline
//   trackEntry_t            : one stage of the in-flight tracking pipeline
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One accepted transfer travelling towards the read-return cycle.
  typedef struct packed {
    logic valid;
    logic portId;
    logic isRead;
  } trackEntry_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a one-bit priority pointer.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   i_req_a, i_req_b    : requests from port A / port B
//   o_gnt_a, o_gnt_b    : combinational grants (one-hot or zero)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_rr;

  // A lone requester wins immediately; on contention the pointer decides.
  // Grants are forced low while reset is asserted.
  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (!reset) begin
      if (i_req_a && (!i_req_b || r_rr == PORT_A)) begin
        o_gnt_a = 1'b1;
      end else if (i_req_b) begin
        o_gnt_b = 1'b1;
      end
    end
  end

  // Grants are only given to requesting ports, so a grant is an accepted
  // transfer; the pointer then favours the other port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr <= PORT_A;
    end else if (o_gnt_a) begin
      r_rr <= PORT_B;
    end else if (o_gnt_b) begin
      r_rr <= PORT_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous single-port RAM between two requesters.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   req_x, we_x, addr_x, wdata_x    : request, write enable, address, data
//   gnt_x                           : combinational accept
//   rvalid_x                        : one-cycle read-return pulse per port
//   rdata                           : shared read data (valid with rvalid_x)
//   mem_addr, mem_write, mem_wdata  : registered RAM command
//   mem_rdata                       : RAM read output, one cycle after read
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          w_xferA;
  logic          w_xferB;
  logic          w_xfer;
  logic          w_selWe;
  logic [AW-1:0] w_selAddr;
  logic [DW-1:0] w_selWdata;
  trackEntry_t   w_stageIn;

  logic [AW-1:0] r_memAddr;
  logic          r_memWrite;
  logic [DW-1:0] r_memWdata;
  trackEntry_t   r_stage1;
  trackEntry_t   r_stage2;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req_a (req_a),
    .i_req_b (req_b),
    .o_gnt_a (gnt_a),
    .o_gnt_b (gnt_b)
  );

  assign w_xferA = req_a & gnt_a;
  assign w_xferB = req_b & gnt_b;
  assign w_xfer  = w_xferA | w_xferB;

  // Steer the winning port's command onto the RAM side; A is the default
  // when nothing transfers, its value is ignored in that case.
  always_comb begin
    w_selWe    = we_a;
    w_selAddr  = addr_a;
    w_selWdata = wdata_a;
    if (w_xferB) begin
      w_selWe    = we_b;
      w_selAddr  = addr_b;
      w_selWdata = wdata_b;
    end
  end

  always_comb begin
    w_stageIn        = '0;
    w_stageIn.valid  = w_xfer;
    w_stageIn.portId = w_xferB ? PORT_B : PORT_A;
    w_stageIn.isRead = w_xfer & ~w_selWe;
  end

  // Address and data hold on idle cycles; only the write strobe drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memAddr  <= '0;
      r_memWrite <= 1'b0;
      r_memWdata <= '0;
    end else begin
      r_memWrite <= w_xfer & w_selWe;
      if (w_xfer) begin
        r_memAddr  <= w_selAddr;
        r_memWdata <= w_selWdata;
      end
    end
  end

  // Stage 1 lines up with the RAM command, stage 2 with the RAM read data,
  // so one transfer per cycle can be in flight without stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= w_stageIn;
      r_stage2 <= r_stage1;
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_write = r_memWrite;
  assign mem_wdata = r_memWdata;

  assign rvalid_a = r_stage2.valid & r_stage2.isRead & (r_stage2.portId == PORT_A);
  assign rvalid_b = r_stage2.valid & r_stage2.isRead & (r_stage2.portId == PORT_B);
  assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives both ports from per-port transaction queues, models the RAM, and
// predicts grants, read returns and RAM-side registers from a queue-based
// reference model of the arbitration and memory rules.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       we_a = 1'b0, we_b = 1'b0;
  logic [7:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata, mem_addr, mem_wdata;
  logic       mem_write;
  logic [7:0] mem_rdata = '0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } pend_t;

  txn_t  qA[$];
  txn_t  qB[$];
  pend_t pend[$];

  logic [7:0] shadow [256];
  logic [7:0] ram [256];
  logic       preloadEn = 1'b0;
  logic [7:0] preAddr = '0, preData = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       mRr = 1'b0;
  logic       mMemWrite = 1'b0;
  logic [7:0] mMemAddr = '0, mMemWdata = '0;
  logic       eGa, eGb, eRva, eRvb;
  logic [7:0] eRdata;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .wdata_a   (wdata_a),
    .wdata_b   (wdata_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: a write command leaves the read output untouched.
  always @(posedge clk) begin
    if (preloadEn) ram[preAddr] <= preData;
    else if (mem_write) ram[mem_addr] <= mem_wdata;
    else mem_rdata <= ram[mem_addr];
  end

  task automatic driveHeads();
    req_a = (qA.size() > 0);
    req_b = (qB.size() > 0);
    if (req_a) begin we_a = qA[0].we; addr_a = qA[0].addr; wdata_a = qA[0].data; end
    if (req_b) begin we_b = qB[0].we; addr_b = qB[0].addr; wdata_b = qB[0].data; end
  endtask

  // Expected outputs for the current cycle from the arbitration rules.
  task automatic modelPredict();
    eGa = 1'b0; eGb = 1'b0; eRva = 1'b0; eRvb = 1'b0; eRdata = '0;
    if (!reset) begin
      if (req_a && req_b) begin
        eGa = (mRr == 1'b0);
        eGb = (mRr == 1'b1);
      end else begin
        eGa = req_a;
        eGb = req_b;
      end
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) eRvb = 1'b1; else eRva = 1'b1;
      eRdata = pend[0].data;
    end
  endtask

  // Apply this cycle's accepted transfer to the model state.
  task automatic modelCommit();
    txn_t t;
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    mMemWrite = 1'b0;
    if (eGa || eGb) begin
      t = eGa ? qA.pop_front() : qB.pop_front();
      mMemWrite = t.we;
      mMemAddr  = t.addr;
      mMemWdata = t.data;
      if (t.we) shadow[t.addr] = t.data;
      else pend.push_back('{cyc + 2, eGb, shadow[t.addr]});
      mRr = eGa ? 1'b1 : 1'b0;
    end
    cyc++;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset = 1'b1;
    qA.delete(); qB.delete();
    driveHeads();
    pend.delete();
    mRr = 1'b0; mMemWrite = 1'b0; mMemAddr = '0; mMemWdata = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) shadow[i] = 8'($urandom);
    for (int k = 0; k < 4; k++) shadow[8'h20 + k] = 8'(8'hC0 + k);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      preloadEn = 1'b1; preAddr = 8'(i); preData = shadow[i];
    end
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_gnt actual=%b required=00", {gnt_a, gnt_b});
    end
    checks++;
    if ({rvalid_a, rvalid_b, mem_write} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags actual=%b required=000", {rvalid_a, rvalid_b, mem_write});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_memregs actual=%h required=0000", {mem_addr, mem_wdata});
    end
    doReset(1);
  endtask

  task automatic test_write_read();
    int gntCyc[$];
    int rvCyc = -1;
    logic [7:0] rvData = '0;
    int guard = 0;
    qA.push_back('{1'b1, 8'h10, 8'h5A});
    qA.push_back('{1'b0, 8'h10, 8'h00});
    while ((qA.size() || qB.size() || pend.size()) && guard < 20) begin
      @(negedge clk); driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL wr_rd_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      checks++;
      if ({rvalid_a, rvalid_b} !== {eRva, eRvb}) begin
        errors++; $display("[TB] FAIL wr_rd_rvalid actual=%b required=%b", {rvalid_a, rvalid_b}, {eRva, eRvb});
      end
      if (gnt_a) gntCyc.push_back(guard);
      if (rvalid_a) begin rvCyc = guard; rvData = rdata; end
      modelCommit();
      guard++;
    end
    checks++;
    if (gntCyc.size() != 2 || gntCyc[1] != gntCyc[0] + 1) begin
      errors++; $display("[TB] FAIL wr_rd_grants actual=%0d grants required=2 consecutive", gntCyc.size());
    end
    checks++;
    if (gntCyc.size() != 2 || rvCyc != gntCyc[1] + 2 || rvData !== 8'h5A) begin
      errors++; $display("[TB] FAIL wr_rd_data actual=cycle %0d data %h required=2 after read grant data 5a", rvCyc, rvData);
    end
  endtask

  task automatic test_alternate();
    logic grantSeq[$];
    int guard = 0;
    doReset(2);
    for (int k = 0; k < 4; k++) begin
      qA.push_back('{1'b0, 8'h01, 8'h00});
      qB.push_back('{1'b0, 8'h02, 8'h00});
    end
    while ((qA.size() || qB.size() || pend.size()) && guard < 30) begin
      @(negedge clk); driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL alt_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      checks++;
      if ({rvalid_a, rvalid_b} !== {eRva, eRvb}) begin
        errors++; $display("[TB] FAIL alt_rvalid actual=%b required=%b", {rvalid_a, rvalid_b}, {eRva, eRvb});
      end
      if (eRva || eRvb) begin
        checks++;
        if (rdata !== eRdata) begin
          errors++; $display("[TB] FAIL alt_rdata actual=%h required=%h", rdata, eRdata);
        end
      end
      if (gnt_a || gnt_b) grantSeq.push_back(gnt_b);
      modelCommit();
      guard++;
    end
    checks++;
    if (grantSeq.size() != 8) begin
      errors++; $display("[TB] FAIL alt_count actual=%0d required=8", grantSeq.size());
    end
    for (int k = 0; k < grantSeq.size(); k++) begin
      checks++;
      if (grantSeq[k] !== logic'(k % 2)) begin
        errors++; $display("[TB] FAIL alt_order actual=%b required=%b at grant %0d", grantSeq[k], logic'(k % 2), k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gntCyc[$];
    int rvCyc[$];
    logic [7:0] rvData[$];
    int guard = 0;
    for (int k = 0; k < 4; k++) qB.push_back('{1'b0, 8'(8'h20 + k), 8'h00});
    while ((qA.size() || qB.size() || pend.size()) && guard < 30) begin
      @(negedge clk); driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL b2b_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      checks++;
      if ({rvalid_a, rvalid_b} !== {eRva, eRvb}) begin
        errors++; $display("[TB] FAIL b2b_rvalid actual=%b required=%b", {rvalid_a, rvalid_b}, {eRva, eRvb});
      end
      if (gnt_b) gntCyc.push_back(guard);
      if (rvalid_b) begin rvCyc.push_back(guard); rvData.push_back(rdata); end
      modelCommit();
      guard++;
    end
    checks++;
    if (gntCyc.size() != 4 || rvCyc.size() != 4) begin
      errors++; $display("[TB] FAIL b2b_count actual=%0d grants %0d returns required=4 and 4", gntCyc.size(), rvCyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gntCyc[k] != gntCyc[0] + k || rvCyc[k] != gntCyc[0] + 2 + k || rvData[k] !== 8'(8'hC0 + k)) begin
          errors++; $display("[TB] FAIL b2b_seq actual=gnt %0d rv %0d data %h required=gnt %0d rv %0d data %h",
                             gntCyc[k], rvCyc[k], rvData[k], gntCyc[0] + k, gntCyc[0] + 2 + k, 8'(8'hC0 + k));
        end
      end
    end
  endtask

  task automatic test_contend();
    int firstPort = -1;
    logic [7:0] bData = '0;
    int bCount = 0;
    int guard = 0;
    doReset(1);
    qA.push_back('{1'b1, 8'h30, 8'h77});
    qB.push_back('{1'b0, 8'h30, 8'h00});
    while ((qA.size() || qB.size() || pend.size()) && guard < 20) begin
      @(negedge clk); driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL contend_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      if (firstPort < 0 && (gnt_a || gnt_b)) firstPort = gnt_b ? 1 : 0;
      if (rvalid_b) begin bData = rdata; bCount++; end
      modelCommit();
      guard++;
    end
    checks++;
    if (firstPort != 0) begin
      errors++; $display("[TB] FAIL contend_first actual=%0d required=0", firstPort);
    end
    checks++;
    if (bCount != 1 || bData !== 8'h77) begin
      errors++; $display("[TB] FAIL contend_rdata actual=%0d returns data %h required=1 return data 77", bCount, bData);
    end
  endtask

  task automatic test_reset_mid();
    qA.push_back('{1'b0, 8'h10, 8'h00});
    @(negedge clk); driveHeads(); #1; modelPredict();
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_gnt actual=%b required=1", gnt_a);
    end
    modelCommit();
    @(negedge clk);
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    pend.delete();
    mRr = 1'b0; mMemWrite = 1'b0; mMemAddr = '0; mMemWdata = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_write} !== 5'b00000) begin
        errors++; $display("[TB] FAIL rstmid_flags actual=%b required=00000", {gnt_a, gnt_b, rvalid_a, rvalid_b, mem_write});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 16'h0000) begin
        errors++; $display("[TB] FAIL rstmid_memregs actual=%h required=0000", {mem_addr, mem_wdata});
      end
      @(negedge clk);
    end
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({rvalid_a, rvalid_b} !== 2'b00) begin
        errors++; $display("[TB] FAIL rstmid_stale actual=%b required=00", {rvalid_a, rvalid_b});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    int guard = 0;
    qA.push_back('{1'b1, 8'hFF, 8'h11});
    qA.push_back('{1'b1, 8'h00, 8'h22});
    qA.push_back('{1'b0, 8'hFF, 8'h00});
    qA.push_back('{1'b0, 8'h00, 8'h00});
    while ((qA.size() || qB.size() || pend.size()) && guard < 20) begin
      if (guard > 0) @(negedge clk);
      driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL wrap_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      if (rvalid_a) got.push_back(rdata);
      modelCommit();
      guard++;
    end
    checks++;
    if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22) begin
      errors++; $display("[TB] FAIL wrap_data actual=%0d returns required=11 then 22", got.size());
    end
  endtask

  task automatic test_random();
    int guard = 0;
    while (guard < 300 || ((qA.size() || qB.size() || pend.size()) && guard < 400)) begin
      if (guard < 300) begin
        if (qA.size() == 0 && $urandom_range(2, 0) != 0)
          qA.push_back('{1'($urandom_range(1, 0)), 8'(8'h40 + $urandom_range(3, 0)), 8'($urandom)});
        if (qB.size() == 0 && $urandom_range(2, 0) != 0)
          qB.push_back('{1'($urandom_range(1, 0)), 8'(8'h40 + $urandom_range(3, 0)), 8'($urandom)});
      end
      @(negedge clk); driveHeads(); #1; modelPredict();
      checks++;
      if ({gnt_a, gnt_b} !== {eGa, eGb}) begin
        errors++; $display("[TB] FAIL rand_gnt actual=%b required=%b", {gnt_a, gnt_b}, {eGa, eGb});
      end
      checks++;
      if ({rvalid_a, rvalid_b} !== {eRva, eRvb}) begin
        errors++; $display("[TB] FAIL rand_rvalid actual=%b required=%b", {rvalid_a, rvalid_b}, {eRva, eRvb});
      end
      if (eRva || eRvb) begin
        checks++;
        if (rdata !== eRdata) begin
          errors++; $display("[TB] FAIL rand_rdata actual=%h required=%h", rdata, eRdata);
        end
      end
      checks++;
      if ({mem_write, mem_addr, mem_wdata} !== {mMemWrite, mMemAddr, mMemWdata}) begin
        errors++; $display("[TB] FAIL rand_memside actual=%b/%h/%h required=%b/%h/%h",
                           mem_write, mem_addr, mem_wdata, mMemWrite, mMemAddr, mMemWdata);
      end
      modelCommit();
      guard++;
    end
    checks++;
    if (qA.size() || qB.size() || pend.size()) begin
      errors++; $display("[TB] FAIL rand_drain actual=%0d outstanding required=0", qA.size() + qB.size() + pend.size());
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_contend();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
